// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and the
// mapping from state to the side that currently owns the memory handshake.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_I    = 2'd1;
    localparam logic [1:0] OWNER_D    = 2'd2;

    function automatic logic [1:0] state_owner(input state_t s);
        logic [1:0] owner;
        case (s)
            IBUSY:   owner = OWNER_I;
            DBUSY:   owner = OWNER_D;
            default: owner = OWNER_NONE;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store sides onto one memory handshake; data wins
// by default, a bounded data streak keeps fetch from being starved.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_byte,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_byte,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] DSTREAK_LIMIT = SW'(MAX_DSTREAK);

    state_t        state_reg;
    state_t        state_next;
    logic          grant_i;
    logic          grant_d;
    logic          complete_i;
    logic          complete_d;
    logic [1:0]    owner;
    logic          i_elig;
    logic          d_elig;
    logic [SW-1:0] dstreak_reg;
    logic          mem_we_reg;
    logic          mem_byte_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [DW-1:0] i_rdata_reg;
    logic [DW-1:0] d_rdata_reg;
    logic          i_done_reg;
    logic          d_done_reg;

    // A side whose done pulse is high is dropping its request this cycle.
    assign i_elig = i_req && !i_done_reg;
    assign d_elig = d_req && !d_done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_elig && (!i_elig || (dstreak_reg < DSTREAK_LIMIT))) begin
                    state_next = DBUSY;
                    grant_d    = 1'b1;
                end else if (i_elig) begin
                    state_next = IBUSY;
                    grant_i    = 1'b1;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        owner      = state_owner(state_reg);
        mem_req    = (owner != OWNER_NONE);
        complete_i = (owner == OWNER_I) && mem_ready;
        complete_d = (owner == OWNER_D) && mem_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_reg    <= 1'b0;
            mem_byte_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            dstreak_reg   <= '0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            i_done_reg    <= 1'b0;
            d_done_reg    <= 1'b0;
        end else begin
            i_done_reg <= complete_i;
            d_done_reg <= complete_d;
            if (complete_i) begin
                i_rdata_reg <= mem_rdata;
            end
            // Stores complete without touching the load-data register.
            if (complete_d && !mem_we_reg) begin
                d_rdata_reg <= mem_rdata;
            end
            if (grant_d) begin
                mem_we_reg    <= d_we;
                mem_byte_reg  <= d_byte;
                mem_addr_reg  <= d_addr;
                mem_wdata_reg <= d_wdata;
                if (!i_req) begin
                    dstreak_reg <= '0;
                end else if (dstreak_reg != DSTREAK_LIMIT) begin
                    dstreak_reg <= dstreak_reg + SW'(1);
                end
            end else if (grant_i) begin
                mem_we_reg    <= 1'b0;
                mem_byte_reg  <= 1'b0;
                mem_addr_reg  <= i_addr;
                mem_wdata_reg <= '0;
                dstreak_reg   <= '0;
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_byte  = mem_byte_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign i_done    = i_done_reg;
    assign d_done    = d_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, fetch, priority,
// store with wait states, streak limit, mid-transaction reset, spurious ready.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_byte = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        checks++; if ({mem_req, mem_we, mem_byte, i_done, d_done} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {mem_req, mem_we, mem_byte, i_done, d_done}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", i_rdata, d_rdata); end
        reset = 0;
        tick();
        $display("reset: released");
    endtask

    task automatic test_single_fetch();
        i_req = 1; i_addr = 32'h10; mem_rdata = 32'h00500113; mem_ready = 1;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_grant got req=%b addr=%h we=%b want 1/00000010/0", mem_req, mem_addr, mem_we); end
        checks++; if (i_done !== 1'b0) begin errors++; $display("FAIL fetch_early_done got %b want 0", i_done); end
        tick();
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h00500113) begin errors++; $display("FAIL fetch_done got done=%b rdata=%h want 1/00500113", i_done, i_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_release got mem_req=%b want 0", mem_req); end
        i_req = 0;
        tick();
        checks++; if (i_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_pulse got done=%b req=%b want 0/0", i_done, mem_req); end
        mem_ready = 0;
        $display("single fetch: addr 00000010 rdata %h", i_rdata);
    endtask

    task automatic test_spurious_ready();
        mem_ready = 1; mem_rdata = 32'hFFFF0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({i_done, d_done, mem_req} !== 3'b000) begin errors++; $display("FAIL spurious_done cycle %0d got %b want 000", k, {i_done, d_done, mem_req}); end
        end
        checks++; if (i_rdata !== 32'h00500113 || d_rdata !== 32'h0) begin errors++; $display("FAIL spurious_rdata got %h/%h want 00500113/00000000", i_rdata, d_rdata); end
        mem_ready = 0;
        $display("spurious ready: ignored");
    endtask

    task automatic test_simultaneous();
        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h40;
        mem_rdata = 32'h7; mem_ready = 1;
        tick();
        checks++; if (mem_addr !== 32'h40 || mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL prio_data_first got addr=%h req=%b we=%b want 00000040/1/0", mem_addr, mem_req, mem_we); end
        tick();
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h7 || i_done !== 1'b0) begin errors++; $display("FAIL prio_data_done got d_done=%b d_rdata=%h i_done=%b want 1/00000007/0", d_done, d_rdata, i_done); end
        d_req = 0; mem_rdata = 32'h13;
        tick();
        checks++; if (mem_addr !== 32'h20 || mem_req !== 1'b1 || d_done !== 1'b0) begin errors++; $display("FAIL prio_fetch_next got addr=%h req=%b d_done=%b want 00000020/1/0", mem_addr, mem_req, d_done); end
        tick();
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h13) begin errors++; $display("FAIL prio_fetch_done got done=%b rdata=%h want 1/00000013", i_done, i_rdata); end
        i_req = 0; mem_ready = 0;
        tick();
        $display("simultaneous: data then fetch");
    endtask

    task automatic test_store_wait();
        d_req = 1; d_we = 1; d_byte = 1; d_addr = 32'h44; d_wdata = 32'hAB;
        mem_ready = 0; mem_rdata = 32'hDEADBEEF;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1;
            checks++; if ({mem_req, mem_we, mem_byte} !== 3'b111 || mem_addr !== 32'h44 || mem_wdata !== 32'hAB) begin errors++; $display("FAIL store_stable cycle %0d got %b addr=%h wdata=%h want 111/00000044/000000ab", k, {mem_req, mem_we, mem_byte}, mem_addr, mem_wdata); end
            checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL store_early_done cycle %0d got %b want 0", k, d_done); end
            d_addr = 32'h99; d_wdata = 32'h55;
            tick();
        end
        checks++; if (d_done !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL store_done got done=%b req=%b want 1/0", d_done, mem_req); end
        checks++; if (d_rdata !== 32'h7) begin errors++; $display("FAIL store_rdata got %h want 00000007", d_rdata); end
        d_req = 0; d_we = 0; d_byte = 0; mem_ready = 0;
        tick();
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL store_pulse got %b want 0", d_done); end
        $display("store: addr 00000044 wdata 000000ab 3 wait cycles");
    endtask

    task automatic test_streak();
        idle_inputs();
        reset = 1; tick(); reset = 0;
        d_addr = 32'h80; i_addr = 32'h30; mem_ready = 1;
        for (int r = 0; r < 4; r++) begin
            i_req = 1; d_req = 1;
            tick();
            checks++; if (mem_addr !== 32'h80 || mem_req !== 1'b1) begin errors++; $display("FAIL streak_data_grant round %0d got addr=%h req=%b want 00000080/1", r, mem_addr, mem_req); end
            i_req = 0;
            tick();
            checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL streak_data_done round %0d got %b want 1", r, d_done); end
            tick();
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL streak_idle round %0d got %b want 0", r, mem_req); end
        end
        i_req = 1;
        tick();
        checks++; if (mem_addr !== 32'h30 || mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL streak_fetch_grant got addr=%h req=%b we=%b want 00000030/1/0", mem_addr, mem_req, mem_we); end
        tick();
        checks++; if (i_done !== 1'b1 || d_done !== 1'b0) begin errors++; $display("FAIL streak_fetch_done got %b/%b want 1/0", i_done, d_done); end
        // Data granted with i_req high: a cleared counter leaves room for another data win.
        tick();
        checks++; if (mem_addr !== 32'h80 || mem_req !== 1'b1) begin errors++; $display("FAIL streak_after_fetch got addr=%h req=%b want 00000080/1", mem_addr, mem_req); end
        i_req = 0;
        tick();
        tick();
        i_req = 1;
        tick();
        checks++; if (mem_addr !== 32'h80 || mem_req !== 1'b1) begin errors++; $display("FAIL streak_cleared got addr=%h req=%b want 00000080/1", mem_addr, mem_req); end
        i_req = 0; d_req = 0;
        tick();
        tick();
        mem_ready = 0;
        $display("streak: 4 data grants then fetch");
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        d_req = 1; d_addr = 32'h60;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin errors++; $display("FAIL midreset_busy got req=%b addr=%h want 1/00000060", mem_req, mem_addr); end
        #1 reset = 1;
        #1;
        checks++; if ({mem_req, i_done, d_done} !== 3'b000 || mem_addr !== 32'h0) begin errors++; $display("FAIL midreset_clear got %b addr=%h want 000/00000000", {mem_req, i_done, d_done}, mem_addr); end
        d_req = 0;
        tick();
        reset = 0;
        i_req = 1; i_addr = 32'h70; mem_rdata = 32'h1234; mem_ready = 1;
        tick();
        checks++; if (mem_addr !== 32'h70 || mem_req !== 1'b1) begin errors++; $display("FAIL midreset_fetch_grant got addr=%h req=%b want 00000070/1", mem_addr, mem_req); end
        tick();
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h1234 || d_done !== 1'b0) begin errors++; $display("FAIL midreset_fetch_done got %b/%h/%b want 1/00001234/0", i_done, i_rdata, d_done); end
        i_req = 0; mem_ready = 0;
        tick();
        $display("reset mid-transaction: recovered");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_spurious_ready();
        test_simultaneous();
        test_store_wait();
        test_streak();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
